// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone B3 encodings and initiator state type.
package peripheral_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE} state_e;
endpackage

// File: rtl/peripheral_wb_adr_gen.sv
// Next burst address: +DW/8, with the low bits wrapping inside the BTE window.
module peripheral_wb_adr_gen
  import peripheral_wb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0] adr,
  input  logic [1:0]    bte,
  output logic [AW-1:0] nxt_adr
);
  localparam int BW = $clog2(DW/8);
  localparam logic [AW-1:0] STEP = AW'(DW/8);

  logic [AW-1:0] inc;
  logic [AW-1:0] mask;

  always_comb begin
    inc = adr + STEP;
    case (bte)
      BTE_WRAP4:  mask = AW'((4  << BW) - 1);
      BTE_WRAP8:  mask = AW'((8  << BW) - 1);
      BTE_WRAP16: mask = AW'((16 << BW) - 1);
      default:    mask = '1;
    endcase
    // bits above the wrap window stay fixed
    nxt_adr = (adr & ~mask) | (inc & mask);
  end
endmodule

// File: rtl/peripheral_mpram_wb_initiator.sv
// Command-driven Wishbone B3 burst initiator: cmd/wdata/rdata stream to WB master.
module peripheral_mpram_wb_initiator
  import peripheral_wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_adr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [1:0]        cmd_bte,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic [DW-1:0]     wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i
);
  localparam int SW = DW/8;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              we_q, we_d, len0_q, len0_d, err_q, err_d, rd_valid_q, rd_valid_d;
  logic [AW-1:0]     adr_q, adr_d, nxt_adr;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        bte_q, bte_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [TW-1:0]     to_q, to_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              xfer, stb, ack_v, err_v;

  peripheral_wb_adr_gen #(.AW(AW), .DW(DW)) u_adr_gen (
    .adr(adr_q), .bte(bte_q), .nxt_adr(nxt_adr)
  );

  assign xfer  = (state_q == ST_XFER);
  assign stb   = xfer && !(we_q && !wr_valid);
  assign err_v = stb && wb_err_i;
  // a retry response never retires the beat
  assign ack_v = stb && wb_ack_i && !wb_err_i && !wb_rty_i;

  assign cmd_ready = (state_q == ST_IDLE) && !wb_rst_i;
  assign wr_ready  = ack_v && we_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = (state_q == ST_DONE);
  assign err       = done && err_q;
  assign wb_cyc_o  = xfer;
  assign wb_stb_o  = stb;
  assign wb_we_o   = xfer && we_q;
  assign wb_adr_o  = xfer ? adr_q : '0;
  assign wb_sel_o  = xfer ? sel_q : '0;
  assign wb_bte_o  = xfer ? bte_q : '0;
  assign wb_dat_o  = (stb && we_q) ? wr_data : '0;
  assign wb_cti_o  = !xfer  ? CTI_CLASSIC :
                     len0_q ? CTI_CLASSIC :
                     (cnt_q == '0) ? CTI_EOB : CTI_INC;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    len0_d     = len0_q;
    err_d      = err_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    bte_d      = bte_q;
    sel_d      = sel_q;
    to_d       = to_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        we_d    = cmd_we;
        adr_d   = cmd_adr;
        cnt_d   = cmd_len;
        len0_d  = (cmd_len == '0);
        bte_d   = cmd_bte;
        sel_d   = cmd_sel;
        err_d   = 1'b0;
        to_d    = '0;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        if (err_v) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (ack_v) begin
          adr_d = nxt_adr;
          cnt_d = cnt_q - 1'b1;
          to_d  = '0;
          if (!we_q) begin
            rd_data_d  = wb_dat_i;
            rd_valid_d = 1'b1;
          end
          if (cnt_q == '0) state_d = ST_DONE;
        end else if (stb) begin
          if (to_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      len0_q     <= 1'b0;
      err_q      <= 1'b0;
      adr_q      <= '0;
      cnt_q      <= '0;
      bte_q      <= '0;
      sel_q      <= '0;
      to_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      len0_q     <= len0_d;
      err_q      <= err_d;
      adr_q      <= adr_d;
      cnt_q      <= cnt_d;
      bte_q      <= bte_d;
      sel_q      <= sel_d;
      to_q       <= to_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
endmodule

// File: tb/tb_peripheral_mpram_wb_initiator.sv
// Initiator driven into a behavioural WB memory responder; checked against a burst-level model.
module tb_peripheral_mpram_wb_initiator;
  localparam int AW = 32, DW = 32, LEN_W = 4, TIMEOUT = 16;

  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [AW-1:0] cmd_adr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [1:0] cmd_bte = '0;
  logic [3:0] cmd_sel = '0;
  logic [DW-1:0] wr_data = '0, rd_data, wb_dat_i = '0, wb_dat_o;
  logic wr_valid = 0, wr_ready, rd_valid, done, err;
  logic [AW-1:0] wb_adr_o;
  logic [3:0] wb_sel_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0] wb_cti_o;
  logic [1:0] wb_bte_o;
  logic wb_ack_i = 0, wb_err_i = 0, wb_rty_i = 0;

  always #100 wb_clk_i = ~wb_clk_i;

  peripheral_mpram_wb_initiator #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_bte(cmd_bte), .cmd_sel(cmd_sel),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .err(err), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  logic [31:0] smem [1024];  // responder storage, written from bus signals
  logic [31:0] mmem [1024];  // model storage, written from intended addresses/data
  int n_chk = 0, n_fail = 0;
  logic [31:0] rd_log[$];
  int stall_seen, stb_cycles;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_adr(input logic [31:0] a, input logic [1:0] bte, input int i);
    int span;
    logic [31:0] base, off;
    if (bte == 2'b00) return a + 32'(i * 4);
    span = 4 << (int'(bte) + 1);
    base = a & ~32'(span - 1);
    off  = (a - base + 32'(i * 4)) % 32'(span);
    return base + off;
  endfunction

  task automatic run_cmd(input logic we, input logic [31:0] adr, input int len, input logic [1:0] bte,
                         input logic [3:0] sel, input int dmode, input int err_beat, input bit noack,
                         input int stall_beat, input int rst_at);
    logic [31:0] ea[$], wd[$], er[$];
    logic [31:0] a, d;
    int wbeat, rbeat, beats, stall_left, exp_beats, idx;
    bit got_done;
    wbeat = 0; rbeat = 0; beats = len + 1; stall_left = 3; got_done = 0;
    stall_seen = 0; stb_cycles = 0; rd_log.delete();
    for (int i = 0; i < beats; i++) begin
      ea.push_back(model_adr(adr, bte, i));
      wd.push_back(dmode == 1 ? 32'(i) * 32'h11111111 : dmode == 2 ? 32'hDEADBEEF : $urandom);
    end
    exp_beats = (err_beat >= 0) ? err_beat : noack ? 0 : beats;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_len = LEN_W'(len); cmd_bte = bte; cmd_sel = sel;
    @(negedge wb_clk_i);
    cmd_valid = 0; cmd_adr = $urandom; cmd_len = LEN_W'($urandom); cmd_bte = 2'($urandom);
    cmd_sel = 4'($urandom); cmd_we = 1'($urandom);
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      if (cyc == rst_at) begin
        wb_rst_i = 1; wr_valid = 0;
        @(negedge wb_clk_i);
        chk("rst_cyc", wb_cyc_o, 0); chk("rst_stb", wb_stb_o, 0);
        chk("rst_done", done, 0); chk("rst_ready", cmd_ready, 0);
        wb_rst_i = 0;
        @(negedge wb_clk_i);
        chk("post_rst_done", done, 0); chk("post_rst_ready", cmd_ready, 1);
        return;
      end
      if (rd_valid) begin
        if (rbeat < er.size()) chk("rd_data", rd_data, er[rbeat]);
        else chk("rd_extra_beat", 1, 0);
        rd_log.push_back(rd_data);
        rbeat++;
      end
      if (done) begin
        got_done = 1;
        chk("done_err", err, (err_beat >= 0) || noack);
        chk("done_cyc", wb_cyc_o, 0);
        chk("done_beats", wbeat, exp_beats);
        if (!we) chk("done_rbeats", rbeat, exp_beats);
      end else begin
        if (we) begin
          if (wbeat == stall_beat && stall_left > 0) begin
            wr_valid = 0; stall_left--;
          end else wr_valid = ($urandom_range(0, 3) != 0);
          wr_data = (wbeat < beats) ? wd[wbeat] : $urandom;
        end else wr_valid = 0;
        #1;
        if (wb_stb_o) begin
          stb_cycles++;
          if (wbeat >= beats) chk("beat_overrun", wbeat, beats - 1);
          else begin
            chk("stb_cyc", wb_cyc_o, 1);
            chk("adr", wb_adr_o, ea[wbeat]);
            chk("cti", wb_cti_o, len == 0 ? 3'b000 : wbeat == len ? 3'b111 : 3'b010);
            chk("bte", wb_bte_o, bte);
            chk("we", wb_we_o, we);
            if (we) begin
              chk("sel", wb_sel_o, sel);
              chk("dat_o", wb_dat_o, wd[wbeat]);
            end
            if (noack) ;
            else if (wbeat == err_beat) wb_err_i = 1;
            else begin
              wb_ack_i = ($urandom_range(0, 3) != 0);
              wb_rty_i = !wb_ack_i && ($urandom_range(0, 1) == 1);
            end
            a = wb_adr_o; idx = int'(a[11:2]);
            if (wb_ack_i && !we) wb_dat_i = smem[idx];
            #1;
            chk("wr_ready", wr_ready, wb_ack_i && we);
            if (wb_ack_i) begin
              if (we) begin
                d = smem[idx];
                for (int b = 0; b < 4; b++) if (wb_sel_o[b]) d[8*b +: 8] = wb_dat_o[8*b +: 8];
                smem[idx] = d;
                a = ea[wbeat]; idx = int'(a[11:2]); d = mmem[idx];
                for (int b = 0; b < 4; b++) if (sel[b]) d[8*b +: 8] = wd[wbeat][8*b +: 8];
                mmem[idx] = d;
              end else begin
                a = ea[wbeat]; idx = int'(a[11:2]);
                er.push_back(mmem[idx]);
              end
              wbeat++;
            end
          end
        end else if (wb_cyc_o) begin
          stall_seen++;
          chk("stall_we", we, 1); chk("stall_wrv", wr_valid, 0); chk("stall_dat", wb_dat_o, 0);
        end
        @(negedge wb_clk_i);
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    wr_valid = 0;
    @(negedge wb_clk_i);
    chk("idle_done_low", done, 0); chk("idle_rdv_low", rd_valid, 0); chk("idle_cyc_low", wb_cyc_o, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin smem[i] = 0; mmem[i] = 0; end
    repeat (3) @(negedge wb_clk_i);
    chk("reset_cyc", wb_cyc_o, 0); chk("reset_stb", wb_stb_o, 0); chk("reset_ready", cmd_ready, 0);
    chk("reset_done", done, 0); chk("reset_err", err, 0); chk("reset_rdv", rd_valid, 0);
    chk("reset_wrr", wr_ready, 0); chk("reset_adr", wb_adr_o, 0); chk("reset_cti", wb_cti_o, 0);
    wb_rst_i = 0;
    @(negedge wb_clk_i);
    chk("model_wrap4_1", model_adr(32'h30C, 2'b01, 1), 32'h300);
    chk("model_wrap4_3", model_adr(32'h30C, 2'b01, 3), 32'h308);
    chk("model_wrap8_1", model_adr(32'h11C, 2'b10, 1), 32'h100);
    chk("model_wrap16_2", model_adr(32'h238, 2'b11, 2), 32'h200);
    chk("model_lin_wrap", model_adr(32'hFFFFFFFC, 2'b00, 1), 32'h0);
    // single write then read
    run_cmd(1, 32'h100, 0, 2'b00, 4'hF, 2, -1, 0, -1, -1);
    run_cmd(0, 32'h100, 0, 2'b00, 4'hF, 0, -1, 0, -1, -1);
    chk("t1_rd", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'hDEADBEEF);
    // linear 8-beat
    run_cmd(1, 32'h200, 7, 2'b00, 4'hF, 1, -1, 0, -1, -1);
    run_cmd(0, 32'h200, 7, 2'b00, 4'hF, 0, -1, 0, -1, -1);
    chk("t2_rd7", rd_log.size() > 7 ? rd_log[7] : 32'hX, 32'h77777777);
    // wrap4 read
    run_cmd(1, 32'h300, 3, 2'b00, 4'hF, 1, -1, 0, -1, -1);
    run_cmd(0, 32'h30C, 3, 2'b01, 4'hF, 0, -1, 0, -1, -1);
    chk("t3_rd0", rd_log.size() > 1 ? rd_log[0] : 32'hX, 32'h33333333);
    chk("t3_rd1", rd_log.size() > 1 ? rd_log[1] : 32'hX, 32'h00000000);
    // write stall mid-burst
    run_cmd(1, 32'h400, 3, 2'b00, 4'hF, 0, -1, 0, 2, -1);
    chk("t4_stall_cycles", stall_seen >= 3, 1);
    run_cmd(0, 32'h400, 3, 2'b00, 4'hF, 0, -1, 0, -1, -1);
    // error on beat 2, then no-ack timeout
    run_cmd(1, 32'h500, 3, 2'b00, 4'hF, 0, 2, 0, -1, -1);
    run_cmd(0, 32'h500, 3, 2'b00, 4'hF, 0, -1, 1, -1, -1);
    chk("t5_timeout_len", stb_cycles, TIMEOUT);
    // reset mid 16-beat burst, then a clean command
    run_cmd(1, 32'h600, 15, 2'b00, 4'hF, 0, -1, 0, -1, 6);
    run_cmd(0, 32'h100, 0, 2'b00, 4'hF, 0, -1, 0, -1, -1);
    chk("t6_rd", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'hDEADBEEF);
    for (int n = 0; n < 40; n++)
      run_cmd(1'($urandom), {20'h0, 10'($urandom), 2'b00}, $urandom_range(0, 15),
              2'($urandom), 4'($urandom), 0, -1, 0, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
